// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps all 16 {a,b,c,d} vectors into a combinational
// block, samples its response x_in after a settle time, builds the observed
// truth table and compares it against EXPECTED, reporting pass/fail.
module truth_table_checker #(
   parameter logic [15:0] EXPECTED      = 16'h0000,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        x_in,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] table_out,
   output logic [4:0]  err_count,
   output logic [3:0]  first_err_idx,
   output logic        err_valid
);

   localparam int unsigned IDX_W = 4;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned ERR_W = 5;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(15);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] cnt;
   logic             mismatch;
   logic [ERR_W-1:0] err_next;

   // Stimulus vector comes straight from the index register.
   assign {a, b, c, d} = idx;

   // Response check for the vector currently being sampled.
   assign mismatch = (x_in != EXPECTED[idx]);
   assign err_next = err_count + ERR_W'(mismatch);

   // Sweep sequencer with registered status and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         cnt           <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         table_out     <= '0;
         err_count     <= '0;
         first_err_idx <= '0;
         err_valid     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state         <= SETTLE;
                  idx           <= '0;
                  cnt           <= '0;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  pass          <= 1'b0;
                  table_out     <= '0;
                  err_count     <= '0;
                  first_err_idx <= '0;
                  err_valid     <= 1'b0;
               end
            end
            SETTLE: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               table_out[idx] <= x_in;
               if (mismatch) begin
                  err_count <= err_next;
                  if (!err_valid) begin
                     first_err_idx <= idx;
                     err_valid     <= 1'b1;
                  end
               end
               if (idx == IDX_LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
               end else begin
                  idx   <= idx + IDX_W'(1);
                  cnt   <= '0;
                  state <= SETTLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: directed sweeps with a scoreboard of
// expected final results checked whenever done rises.
module tb_truth_table_checker;

   typedef struct {
      logic [15:0] tbl;
      logic [4:0]  errs;
      logic [3:0]  fei;
      logic        ev;
      logic        ps;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;

   // Instance 0: default settle time.
   logic        start0 = 1'b0;
   logic [1:0]  mode0 = 2'd0;
   logic        x0;
   logic        a0, b0, c0, d0, busy0, done0, pass0, ev0;
   logic [15:0] tbl0;
   logic [4:0]  ec0;
   logic [3:0]  fei0;
   logic        done0_q = 1'b0;
   exp_t        q0[$];
   exp_t        e0;

   // Instance 1: longer settle time.
   logic        start1 = 1'b0;
   logic        x1;
   logic        a1, b1, c1, d1, busy1, done1, pass1, ev1;
   logic [15:0] tbl1;
   logic [4:0]  ec1;
   logic [3:0]  fei1;
   logic        done1_q = 1'b0;
   exp_t        q1[$];
   exp_t        e1;

   assign x0 = (mode0 == 2'd0) ? (a0 ^ b0) :
               (mode0 == 2'd1) ? 1'b0 : ~(a0 ^ b0);
   assign x1 = a1 ^ b1;

   truth_table_checker #(.EXPECTED(16'h0FF0), .SETTLE_CYCLES(1)) u0 (
      .clk(clk), .rst(rst), .start(start0), .x_in(x0),
      .a(a0), .b(b0), .c(c0), .d(d0),
      .busy(busy0), .done(done0), .pass(pass0),
      .table_out(tbl0), .err_count(ec0), .first_err_idx(fei0), .err_valid(ev0)
   );

   truth_table_checker #(.EXPECTED(16'h0FF0), .SETTLE_CYCLES(3)) u1 (
      .clk(clk), .rst(rst), .start(start1), .x_in(x1),
      .a(a1), .b(b1), .c(c1), .d(d1),
      .busy(busy1), .done(done1), .pass(pass1),
      .table_out(tbl1), .err_count(ec1), .first_err_idx(fei1), .err_valid(ev1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mon_check(input string tg, input exp_t e, input logic [15:0] t,
                            input logic [4:0] ec, input logic [3:0] fi, input logic ev,
                            input logic ps, input logic bz, input logic [3:0] vec,
                            input int unsigned cy);
      check({tg, "_table"},     32'(t),  32'(e.tbl));
      check({tg, "_err_count"}, 32'(ec), 32'(e.errs));
      check({tg, "_first_err"}, 32'(fi), 32'(e.fei));
      check({tg, "_err_valid"}, 32'(ev), 32'(e.ev));
      check({tg, "_pass"},      32'(ps), 32'(e.ps));
      check({tg, "_busy"},      32'(bz), 32'd0);
      check({tg, "_vec"},       32'(vec), 32'hF);
      check({tg, "_done_cycle"}, cy, e.cyc);
   endtask

   // Scoreboard monitor for instance 0.
   always @(negedge clk) begin
      if (done0 && !done0_q) begin
         if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon0_unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
         end else begin
            e0 = q0.pop_front();
            mon_check("u0", e0, tbl0, ec0, fei0, ev0, pass0, busy0, {a0, b0, c0, d0}, cyc);
         end
      end
      done0_q <= done0;
   end

   // Scoreboard monitor for instance 1.
   always @(negedge clk) begin
      if (done1 && !done1_q) begin
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon1_unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
         end else begin
            e1 = q1.pop_front();
            mon_check("u1", e1, tbl1, ec1, fei1, ev1, pass1, busy1, {a1, b1, c1, d1}, cyc);
         end
      end
      done1_q <= done1;
   end

   // Called on a falling edge; start is accepted on the following rising edge.
   task automatic issue0(input logic [15:0] t, input logic [4:0] e, input logic [3:0] f,
                         input logic ev, input logic ps);
      exp_t x;
      x.tbl = t; x.errs = e; x.fei = f; x.ev = ev; x.ps = ps;
      x.cyc = cyc + 1 + 32;
      q0.push_back(x);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic wait_done0();
      bit ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (done0) ok = 1'b1;
      end
      check("u0_done_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_done1();
      bit ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (done1) ok = 1'b1;
      end
      check("u1_done_timeout", 32'(ok), 32'd1);
   endtask

   initial begin
      exp_t x;
      bit   hit;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_state", {a0, b0, c0, d0, busy0, done0, pass0, tbl0, ec0, fei0, ev0}, 32'd0);

      // Case 1: x = a^b matches EXPECTED.
      mode0 = 2'd0;
      issue0(16'h0FF0, 5'd0, 4'd0, 1'b0, 1'b1);
      check("c1_busy_in_settle", 32'(busy0), 32'd1);
      check("c1_first_vec", 32'({a0, b0, c0, d0}), 32'd0);
      wait_done0();
      repeat (3) @(negedge clk);
      check("c1_idx_holds_15", 32'({a0, b0, c0, d0}), 32'hF);
      check("c1_done_holds", 32'(done0), 32'd1);

      // Case 2: x tied low.
      mode0 = 2'd1;
      issue0(16'h0000, 5'd8, 4'd4, 1'b1, 1'b0);
      wait_done0();

      // Case 3: inverted response.
      mode0 = 2'd2;
      issue0(16'hF00F, 5'd16, 4'd0, 1'b1, 1'b0);
      wait_done0();

      // Case 4: reset mid-sweep at vector 5, then a clean sweep.
      mode0 = 2'd0;
      issue0(16'h0FF0, 5'd0, 4'd0, 1'b0, 1'b1);
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         if ({a0, b0, c0, d0} == 4'd5) hit = 1'b1;
         else @(negedge clk);
      end
      check("c4_reached_idx5", 32'(hit), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(q0.pop_back());
      check("c4_reset_outputs", {a0, b0, c0, d0, busy0, done0, pass0, tbl0, ec0, fei0, ev0}, 32'd0);
      @(negedge clk);
      check("c4_stays_idle", 32'({busy0, done0}), 32'd0);
      issue0(16'h0FF0, 5'd0, 4'd0, 1'b0, 1'b1);
      wait_done0();

      // Case 5: start held high through a sweep, then restart from DONE.
      x.tbl = 16'h0FF0; x.errs = 5'd0; x.fei = 4'd0; x.ev = 1'b0; x.ps = 1'b1;
      x.cyc = cyc + 1 + 32;
      q0.push_back(x);
      start0 = 1'b1;
      wait_done0();
      x.cyc = cyc + 1 + 32;
      q0.push_back(x);
      @(negedge clk);
      start0 = 1'b0;
      check("c5_restart_done", 32'(done0), 32'd0);
      check("c5_restart_busy", 32'(busy0), 32'd1);
      check("c5_restart_cleared", 32'({tbl0, ec0, ev0}), 32'd0);
      check("c5_restart_idx", 32'({a0, b0, c0, d0}), 32'd0);
      wait_done0();

      // Case 6: SETTLE_CYCLES=3, each vector takes 4 clocks.
      x.cyc = cyc + 1 + 64;
      q1.push_back(x);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (3) @(negedge clk);
      check("c6_vec0_held", 32'({a1, b1, c1, d1}), 32'd0);
      @(negedge clk);
      check("c6_vec1_after_4clk", 32'({a1, b1, c1, d1}), 32'd1);
      wait_done1();

      repeat (3) @(negedge clk);
      check("u0_queue_drained", 32'(q0.size()), 32'd0);
      check("u1_queue_drained", 32'(q1.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
